move_cmd_queue: RTL and testbench

- Sits between the four debounced direction buttons (single-clock SCEN pulses from the debouncers) and the game-state FSM's Wait/Merge stage.
- Encodes each press as a one-hot move code and buffers it in a small FIFO.
- Presents the oldest move to the game FSM with a valid/ack handshake, so presses made while a merge pass is running are not lost.
- Offers a flush input so INI/Done states can discard stale moves.

---
 rtl/move_cmd_queue.sv | 130 +++++++++++++
 tb/tb_move_cmd_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_queue.sv
// Direction-press queue: one-hot encodes debounced button pulses and buffers them for the game FSM.
// Optional MOVE_REPEAT_FILTER_EN drops a press that repeats the newest resident move.
module move_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             SCEN_U,
    input  logic             SCEN_D,
    input  logic             SCEN_L,
    input  logic             SCEN_R,
    input  logic             CLEAR,
    input  logic             CMD_ACK,
    output logic             CMD_VALID,
    output logic [3:0]       CMD_DIR,
    output logic [PTR_W:0]   COUNT,
    output logic             OVERFLOW
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    localparam logic [3:0] CODE_UP    = 4'b0001;
    localparam logic [3:0] CODE_DOWN  = 4'b0010;
    localparam logic [3:0] CODE_LEFT  = 4'b0100;
    localparam logic [3:0] CODE_RIGHT = 4'b1000;

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push_req;
    logic [3:0]       code;
    logic             pop;
    logic             pop_eff;
    logic             full;
    logic             repeat_drop;
    logic             push;
    logic             drop_full;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_next;
    logic [3:0]       head_next;

    // Priority encoder: when several buttons fire together only the highest one is queued.
    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        code     = 4'b0000;
        push_req = SCEN_U | SCEN_D | SCEN_L | SCEN_R;
        if (SCEN_U)      code = CODE_UP;
        else if (SCEN_D) code = CODE_DOWN;
        else if (SCEN_L) code = CODE_LEFT;
        else if (SCEN_R) code = CODE_RIGHT;
    end

    assign pop  = CMD_ACK & CMD_VALID;
    assign full = (COUNT == FULL_COUNT);

`ifdef MOVE_REPEAT_FILTER_EN
    logic [3:0] last_code;
    logic       resident;

    // The newest entry survives this cycle unless it is also the head being popped.
    assign last_code   = mem[wr_ptr - PTR_ONE];
    assign resident    = (COUNT > COUNT_ONE) || ((COUNT == COUNT_ONE) && !pop);
    assign repeat_drop = push_req && resident && (code == last_code);
`else
    assign repeat_drop = 1'b0;
`endif

    // A full queue still accepts a press when the head is popped in the same cycle.
    assign push      = push_req && !repeat_drop && (!full || pop) && !CLEAR;
    assign drop_full = push_req && !repeat_drop && full && !pop && !CLEAR;
    assign pop_eff   = pop && !CLEAR;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = COUNT;
        head_next   = 4'b0000;

        if (CLEAR) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)    wr_ptr_next = wr_ptr + PTR_ONE;
            if (pop_eff) rd_ptr_next = rd_ptr + PTR_ONE;
            case ({push, pop_eff})
                2'b10:   count_next = COUNT + COUNT_ONE;
                2'b01:   count_next = COUNT - COUNT_ONE;
                default: count_next = COUNT;
            endcase
        end

        // The slot being written this edge is not yet in mem, so forward the new code.
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next)) head_next = code;
            else                                 head_next = mem[rd_ptr_next];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            COUNT     <= '0;
            CMD_VALID <= 1'b0;
            CMD_DIR   <= 4'b0000;
            OVERFLOW  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            COUNT     <= count_next;
            CMD_VALID <= (count_next != '0);
            CMD_DIR   <= head_next;
            if (CLEAR)          OVERFLOW <= 1'b0;
            else if (drop_full) OVERFLOW <= 1'b1;
        end
    end

    // NOTE: storage has no reset; COUNT and the pointers alone decide which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= code;
    end

endmodule

// File: tb/tb_move_cmd_queue.sv
// Bench for move_cmd_queue: directed plan steps plus randomized traffic against a queue-based model.
module tb_move_cmd_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             CLK;
    logic             RESET_N;
    logic             SCEN_U, SCEN_D, SCEN_L, SCEN_R;
    logic             CLEAR;
    logic             CMD_ACK;
    logic             CMD_VALID;
    logic [3:0]       CMD_DIR;
    logic [PTR_W:0]   COUNT;
    logic             OVERFLOW;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: pending moves, oldest first, plus the sticky overflow flag.
    logic [3:0] mq[$];
    logic       m_ovf;

    move_cmd_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .SCEN_U(SCEN_U), .SCEN_D(SCEN_D), .SCEN_L(SCEN_L), .SCEN_R(SCEN_R),
        .CLEAR(CLEAR), .CMD_ACK(CMD_ACK),
        .CMD_VALID(CMD_VALID), .CMD_DIR(CMD_DIR), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_dir;
        exp_dir = (mq.size() > 0) ? mq[0] : 4'b0000;
        check({tag, ".valid"}, 8'(CMD_VALID), 8'(mq.size() > 0));
        check({tag, ".dir"},   8'(CMD_DIR),   8'(exp_dir));
        check({tag, ".count"}, 8'(COUNT),     8'(mq.size()));
        check({tag, ".ovf"},   8'(OVERFLOW),  8'(m_ovf));
    endtask

    task automatic model_cycle(input logic u, d, l, r, clr, ack);
        logic [3:0] c;
        logic       want, popping, resident;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            return;
        end
        want    = u | d | l | r;
        c       = u ? 4'b0001 : d ? 4'b0010 : l ? 4'b0100 : 4'b1000;
        popping = ack && (mq.size() > 0);
        resident = (mq.size() > 1) || (mq.size() == 1 && !popping);
`ifdef MOVE_REPEAT_FILTER_EN
        if (want && resident && mq[$] == c) want = 1'b0;
`else
        if (resident && 1'b0) want = 1'b0;
`endif
        if (popping) void'(mq.pop_front());
        if (want) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else                   m_ovf = 1'b1;
        end
    endtask

    // Drive one cycle of inputs away from the edge, then advance the model past the edge.
    task automatic step(input logic u, d, l, r, clr, ack);
        @(negedge CLK);
        SCEN_U = u; SCEN_D = d; SCEN_L = l; SCEN_R = r; CLEAR = clr; CMD_ACK = ack;
        @(posedge CLK);
        #1;
        model_cycle(u, d, l, r, clr, ack);
        SCEN_U = 0; SCEN_D = 0; SCEN_L = 0; SCEN_R = 0; CLEAR = 0; CMD_ACK = 0;
    endtask

    initial begin
        logic [3:0] order [4];
        RESET_N = 1'b0;
        SCEN_U = 0; SCEN_D = 0; SCEN_L = 0; SCEN_R = 0; CLEAR = 0; CMD_ACK = 0;
        m_ovf = 1'b0;
        #12;
        check_all("reset");
        check("reset.dir0", 8'(CMD_DIR), 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Single left press, then pop.
        step(0, 0, 1, 0, 0, 0);
        check_all("left");
        check("left.code", 8'(CMD_DIR), 8'h04);
        step(0, 0, 0, 0, 0, 1);
        check_all("left_pop");

        // U, R, D, L on consecutive cycles, then drain in order.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check_all("four");
        check("four.count", 8'(COUNT), 8'd4);
        order[0] = 4'b0001; order[1] = 4'b1000; order[2] = 4'b0010; order[3] = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.code", i), 8'(CMD_DIR), 8'(order[i]));
            step(0, 0, 0, 0, 0, 1);
            check_all($sformatf("drain%0d", i));
        end
        step(0, 0, 0, 0, 0, 1);
        check_all("empty_pop");

        // Fill, overflow, then push with simultaneous pop while full.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_all("fill");
        step(1, 0, 0, 0, 0, 0);
        check_all("overflow");
        check("overflow.flag", 8'(OVERFLOW), 8'd1);
        check("overflow.head", 8'(CMD_DIR), 8'h01);
        step(0, 1, 0, 0, 0, 1);
        check_all("full_push_pop");
        check("full_push_pop.count", 8'(COUNT), 8'd4);

        // Clear, then two buttons in one cycle.
        step(0, 0, 0, 0, 1, 0);
        check_all("clear");
        step(0, 1, 0, 1, 0, 0);
        check_all("multi");
        check("multi.code", 8'(CMD_DIR), 8'h02);
        step(0, 0, 0, 0, 0, 1);

        // Clear beats a coincident press and ack.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_all("three");
        step(1, 0, 0, 0, 1, 1);
        check_all("clear_prio");
        check("clear_prio.count", 8'(COUNT), 8'd0);

        // Asynchronous reset mid-queue, observed between edges.
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_all("async_reset");
        @(negedge CLK);
        RESET_N = 1'b1;

        // Repeated right presses (collapsed only when the filter is built in).
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_all("repeat");
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        check_all("repeat_pop");
        check("repeat_pop.count", 8'(COUNT), 8'd1);
        check("repeat_pop.code", 8'(CMD_DIR), 8'h08);

        // Randomized traffic; ack rate varies by phase so the queue both fills and drains.
        for (int i = 0; i < 600; i++) begin
            int ack_pct;
            ack_pct = (i < 200) ? 20 : (i < 400) ? 70 : 45;
            step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < ack_pct);
            check_all($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
